// File: rtl/demultiplexor_4_20_16x20_pkg.sv
// Shared constants and types for the URCPU register-bank write side.
// The read multiplexor imports the same package so both ends agree on sizes.
package demultiplexor_4_20_16x20_pkg;

    // Default word width of each register bank entry.
    localparam int DEF_WORD_W = 20;

    // Default address width; the bank holds 2**DEF_ADDR_W entries.
    localparam int DEF_ADDR_W = 4;

    // Entry count of the default configuration.
    localparam int NUM_ENTRIES = 2 ** DEF_ADDR_W;

    // One register bank word at the default width.
    typedef logic [DEF_WORD_W-1:0] word_t;

    // Per-entry flag vector at the default entry count.
    typedef logic [NUM_ENTRIES-1:0] entry_mask_t;

endpackage : demultiplexor_4_20_16x20_pkg

// File: rtl/demultiplexor_4_20_16x20_register_20.sv
// Single register bank entry: synchronous active-low reset, synchronous
// clear and load enable. Reset wins over clear, and clear wins over load.
module register_20
    import demultiplexor_4_20_16x20_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    // Entry storage: reset, then clear, then load; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : register_20

// File: rtl/demultiplexor_4_20_16x20.sv
// Registered 1-to-16 write demultiplexor forming the URCPU register bank.
// wr_addr steers an accepted write into one of sixteen entries (a..p), and
// per-entry strobe pulses and sticky written flags are reported to control.
// Every output comes straight from a flop; there is no bypass path.
module demultiplexor_4_20_16x20
    import demultiplexor_4_20_16x20_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_W-1:0]    wr_data,
    input  logic                 clr,
    output logic [WORD_W-1:0]    a,
    output logic [WORD_W-1:0]    b,
    output logic [WORD_W-1:0]    c,
    output logic [WORD_W-1:0]    d,
    output logic [WORD_W-1:0]    e,
    output logic [WORD_W-1:0]    f,
    output logic [WORD_W-1:0]    g,
    output logic [WORD_W-1:0]    h,
    output logic [WORD_W-1:0]    i,
    output logic [WORD_W-1:0]    j,
    output logic [WORD_W-1:0]    k,
    output logic [WORD_W-1:0]    l,
    output logic [WORD_W-1:0]    m,
    output logic [WORD_W-1:0]    n,
    output logic [WORD_W-1:0]    o,
    output logic [WORD_W-1:0]    p,
    output logic [2**ADDR_W-1:0] strobe,
    output logic [2**ADDR_W-1:0] written
);

    localparam int ENTRIES = 2 ** ADDR_W;

    // Write select, one-hot when a write is requested, otherwise all zero.
    logic [ENTRIES-1:0] sel;

    // Contents of every entry, indexed by address.
    logic [WORD_W-1:0]  entry_q [ENTRIES];

    // Address decode; wr_addr is only looked at when wr_en is high, so an
    // unknown address during idle cycles cannot reach any load enable.
    always_comb begin
        sel = '0;
        if (wr_en) begin
            sel[wr_addr] = 1'b1;
        end
    end

    // Sixteen identical entries; clear is routed to every one of them so a
    // write colliding with clr is dropped inside the entry itself.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        register_20 #(
            .WORD_W (WORD_W)
        ) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .load  (sel[gi]),
            .d     (wr_data),
            .q     (entry_q[gi])
        );
    end

    // Strobe is the registered write select: one cycle per accepted write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strobe <= '0;
        end else if (clr) begin
            strobe <= '0;
        end else begin
            strobe <= sel;
        end
    end

    // Written flags accumulate every accepted write until reset or clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            written <= '0;
        end else if (clr) begin
            written <= '0;
        end else begin
            written <= written | sel;
        end
    end

    // Named outputs feed the read multiplexor inputs directly.
    assign a = entry_q[0];
    assign b = entry_q[1];
    assign c = entry_q[2];
    assign d = entry_q[3];
    assign e = entry_q[4];
    assign f = entry_q[5];
    assign g = entry_q[6];
    assign h = entry_q[7];
    assign i = entry_q[8];
    assign j = entry_q[9];
    assign k = entry_q[10];
    assign l = entry_q[11];
    assign m = entry_q[12];
    assign n = entry_q[13];
    assign o = entry_q[14];
    assign p = entry_q[15];

endmodule : demultiplexor_4_20_16x20
